// File: rtl/hwpe_ctrl_package.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_ctrl_package
// Description : Shared types and constants for the HWPE control slice:
//               micro-loop code image, loader word map and loader FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package hwpe_ctrl_package;

  // Capacity of the micro-loop engine
  localparam int unsigned ULOOP_MAX_NB_LOOPS = 6;
  localparam int unsigned ULOOP_MAX_LENGTH   = 32;

  // Loader word map: one word per loop, then two bytecodes per word
  localparam int unsigned ULOOP_LOADER_LOOP_WORDS = ULOOP_MAX_NB_LOOPS;
  localparam int unsigned ULOOP_LOADER_CODE_WORDS = ULOOP_MAX_LENGTH / 2;

  // Bit positions and widths inside a staging word
  localparam int unsigned ULOOP_LOADER_ADDR_LSB    = 0;
  localparam int unsigned ULOOP_LOADER_ADDR_W      = 5;
  localparam int unsigned ULOOP_LOADER_NB_OPS_LSB  = 8;
  localparam int unsigned ULOOP_LOADER_NB_OPS_W    = 4;
  localparam int unsigned ULOOP_LOADER_RANGE_LSB   = 16;
  localparam int unsigned ULOOP_LOADER_RANGE_W     = 12;
  localparam int unsigned ULOOP_LOADER_CODE_LO_LSB = 0;
  localparam int unsigned ULOOP_LOADER_CODE_HI_LSB = 16;
  localparam int unsigned ULOOP_BYTECODE_W         = 11;

  // One bytecode: op_sel, a, b (MSB first)
  typedef struct packed {
    logic       op_sel;
    logic [4:0] a;
    logic [4:0] b;
  } uloop_bytecode_t;

  // One loop descriptor
  typedef struct packed {
    logic [4:0] uloop_addr;
    logic [3:0] nb_ops;
  } uloop_loop_t;

  // Complete code image consumed by the micro-loop engine
  typedef struct packed {
    uloop_loop_t     [ULOOP_MAX_NB_LOOPS-1:0]       loops;
    logic            [ULOOP_MAX_NB_LOOPS-1:0][11:0] range;
    uloop_bytecode_t [ULOOP_MAX_LENGTH-1:0]         code;
  } uloop_code_t;

  // Loader commit state
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ACTIVE  = 2'd1,
    PENDING = 2'd2
  } uloop_loader_state_t;

endpackage
`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_loader_check.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_ctrl_uloop_loader_check
// Description : Combinational sanity check of a staged program. Every loop
//               with a non-zero range must have nb_ops != 0 and must end
//               inside the bytecode store (uloop_addr + nb_ops <= LENGTH).
//               Used only when HWPE_CTRL_ULOOP_LOADER_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_ctrl_uloop_loader_check
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned NB_LOOPS = 6,
  parameter int unsigned LENGTH   = 32
) (
  input  uloop_loop_t [NB_LOOPS-1:0]       loops_i,
  input  logic        [NB_LOOPS-1:0][11:0] range_i,
  output logic                             valid_o
);

  // Any active loop that is empty or runs past the code store fails the program
  always_comb begin
    valid_o = 1'b1;
    for (int l = 0; l < NB_LOOPS; l++) begin
      logic [5:0] loop_end;
      loop_end = {1'b0, loops_i[l].uloop_addr} + {2'b00, loops_i[l].nb_ops};
      if ((range_i[l] != '0) &&
          ((loops_i[l].nb_ops == '0) || (loop_end > 6'(LENGTH))))
        valid_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_loader.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_ctrl_uloop_loader
// Description : Bus-programmable staging buffer for micro-loop code. Software
//               writes loop/bytecode/range words into a staging copy and
//               commits; the copy to the active image only happens while the
//               micro-loop engine is idle. Optional program validity check
//               enabled by defining HWPE_CTRL_ULOOP_LOADER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_ctrl_uloop_loader
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned NB_LOOPS = 6,
  parameter int unsigned LENGTH   = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  input  logic        commit_i,
  input  logic        uloop_busy_i,
  output uloop_code_t code_o,
  output logic        code_valid_o,
  output logic        commit_done_o,
  output logic        pending_o,
  output logic        error_o
);

  localparam int unsigned c_code_words = LENGTH / 2;
  localparam int unsigned c_lidx_w     = $clog2(ULOOP_MAX_NB_LOOPS);
  localparam int unsigned c_cidx_w     = $clog2(ULOOP_MAX_LENGTH);

  uloop_code_t         r_stage;
  uloop_code_t         r_code;
  uloop_loader_state_t r_state, w_state_next;
  logic                r_valid;
  logic                r_done;
  logic [31:0]         r_rdata;

  logic                w_is_loop, w_is_code;
  logic [c_lidx_w-1:0] w_loop_idx;
  logic [c_cidx_w-2:0] w_pair;
  logic [c_cidx_w-1:0] w_lo_idx, w_hi_idx;
  logic [31:0]         w_word, w_mask, w_merged;
  logic                w_unused_bits;
  logic                w_copy_req, w_copy_ok, w_copy_bad, w_check_ok;

  // Address decode: loop words first, then packed bytecode pairs
  assign w_is_loop  = addr_i < 5'(NB_LOOPS);
  assign w_is_code  = !w_is_loop && (addr_i < 5'(NB_LOOPS + c_code_words));
  assign w_loop_idx = addr_i[c_lidx_w-1:0];
  assign w_pair     = (c_cidx_w-1)'(addr_i - 5'(NB_LOOPS));
  assign w_lo_idx   = {w_pair, 1'b0};
  assign w_hi_idx   = {w_pair, 1'b1};

  // Current staging word image; bits without storage read as 0
  always_comb begin
    w_word = '0;
    if (w_is_loop) begin
      w_word[ULOOP_LOADER_ADDR_LSB   +: ULOOP_LOADER_ADDR_W]   = r_stage.loops[w_loop_idx].uloop_addr;
      w_word[ULOOP_LOADER_NB_OPS_LSB +: ULOOP_LOADER_NB_OPS_W] = r_stage.loops[w_loop_idx].nb_ops;
      w_word[ULOOP_LOADER_RANGE_LSB  +: ULOOP_LOADER_RANGE_W]  = r_stage.range[w_loop_idx];
    end else if (w_is_code) begin
      w_word[ULOOP_LOADER_CODE_LO_LSB +: ULOOP_BYTECODE_W] = r_stage.code[w_lo_idx];
      w_word[ULOOP_LOADER_CODE_HI_LSB +: ULOOP_BYTECODE_W] = r_stage.code[w_hi_idx];
    end
  end

  // Byte-enable merge of the write data into the current word
  assign w_mask        = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign w_merged      = (w_word & ~w_mask) | (wdata_i & w_mask);
  // Sink for word bits that have no storage behind them
  assign w_unused_bits = ^w_merged;

  // Staging array: cleared by reset/clear, otherwise updated by bus writes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stage <= '0;
    end else if (clear_i) begin
      r_stage <= '0;
    end else if (wr_en_i) begin
      if (w_is_loop) begin
        r_stage.loops[w_loop_idx].uloop_addr <= w_merged[ULOOP_LOADER_ADDR_LSB   +: ULOOP_LOADER_ADDR_W];
        r_stage.loops[w_loop_idx].nb_ops     <= w_merged[ULOOP_LOADER_NB_OPS_LSB +: ULOOP_LOADER_NB_OPS_W];
        r_stage.range[w_loop_idx]            <= w_merged[ULOOP_LOADER_RANGE_LSB  +: ULOOP_LOADER_RANGE_W];
      end else if (w_is_code) begin
        r_stage.code[w_lo_idx] <= w_merged[ULOOP_LOADER_CODE_LO_LSB +: ULOOP_BYTECODE_W];
        r_stage.code[w_hi_idx] <= w_merged[ULOOP_LOADER_CODE_HI_LSB +: ULOOP_BYTECODE_W];
      end
    end
  end

  // Registered read port returning the pre-write staging word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (clear_i) begin
      r_rdata <= '0;
    end else if (rd_en_i) begin
      r_rdata <= w_word;
    end
  end

`ifdef HWPE_CTRL_ULOOP_LOADER_CHECK_EN
  logic r_error;

  hwpe_ctrl_uloop_loader_check #(
    .NB_LOOPS ( NB_LOOPS ),
    .LENGTH   ( LENGTH   )
  ) i_check (
    .loops_i  ( r_stage.loops[NB_LOOPS-1:0] ),
    .range_i  ( r_stage.range[NB_LOOPS-1:0] ),
    .valid_o  ( w_check_ok                  )
  );

  // Sticky rejection flag, cleared by the next good copy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_error <= 1'b0;
    end else if (clear_i) begin
      r_error <= 1'b0;
    end else if (w_copy_bad) begin
      r_error <= 1'b1;
    end else if (w_copy_ok) begin
      r_error <= 1'b0;
    end
  end

  assign error_o = r_error;
`else
  assign w_check_ok = 1'b1;
  assign error_o    = 1'b0;
`endif

  // Commit FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Commit FSM: decide when to copy and where to go next
  always_comb begin
    w_state_next = r_state;
    w_copy_req   = 1'b0;
    case (r_state)
      EMPTY, ACTIVE: begin
        if (commit_i) begin
          if (uloop_busy_i) w_state_next = PENDING;
          else              w_copy_req   = 1'b1;
        end
      end
      PENDING: begin
        if (!uloop_busy_i) w_copy_req = 1'b1;
      end
      default: w_state_next = EMPTY;
    endcase
    w_copy_ok  = w_copy_req &  w_check_ok;
    w_copy_bad = w_copy_req & ~w_check_ok;
    if (w_copy_ok)       w_state_next = ACTIVE;
    else if (w_copy_bad) w_state_next = r_valid ? ACTIVE : EMPTY;
    // Clear beats any commit or write in the same cycle
    if (clear_i) begin
      w_state_next = EMPTY;
      w_copy_ok    = 1'b0;
      w_copy_bad   = 1'b0;
    end
  end

  // Active image, valid flag and done pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (clear_i) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_copy_ok;
      if (w_copy_ok) begin
        r_code  <= r_stage;
        r_valid <= 1'b1;
      end
    end
  end

  assign code_o        = r_code;
  assign code_valid_o  = r_valid;
  assign commit_done_o = r_done;
  assign pending_o     = (r_state == PENDING);
  assign rdata_o       = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ctrl_uloop_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_ctrl_uloop_loader
// Description : Directed self-checking bench for hwpe_ctrl_uloop_loader.
//               Covers the HWPE_CTRL_ULOOP_LOADER_CHECK_EN variant when the
//               macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_ctrl_uloop_loader;
  import hwpe_ctrl_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        wr_en;
  logic        rd_en;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        commit;
  logic        busy;
  uloop_code_t code;
  logic        code_valid;
  logic        commit_done;
  logic        pending;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  hwpe_ctrl_uloop_loader #(
    .NB_LOOPS ( 6  ),
    .LENGTH   ( 32 )
  ) dut (
    .clk_i         ( clk         ),
    .rst_i         ( rst         ),
    .clear_i       ( clear       ),
    .wr_en_i       ( wr_en       ),
    .rd_en_i       ( rd_en       ),
    .addr_i        ( addr        ),
    .wdata_i       ( wdata       ),
    .be_i          ( be          ),
    .rdata_o       ( rdata       ),
    .commit_i      ( commit      ),
    .uloop_busy_i  ( busy        ),
    .code_o        ( code        ),
    .code_valid_o  ( code_valid  ),
    .commit_done_o ( commit_done ),
    .pending_o     ( pending     ),
    .error_o       ( error       )
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    wr_en = 1'b1; addr = a; wdata = d; be = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0;
    wdata = '0; be = '0; commit = 1'b0; busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_eq("rst_valid",   32'(code_valid), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_done",    32'(commit_done), 32'd0);
    check_eq("rst_error",   32'(error), 32'd0);
    check_eq("rst_rdata",   rdata, 32'd0);
    check_eq("rst_code",    32'(|code), 32'd0);

    // Basic write and commit while idle
    wr(5'd0, 32'h0005_0203, 4'hF);
    wr(5'd6, 32'h0421_0123, 4'hF);
    do_commit();
    check_eq("c1_done",    32'(commit_done), 32'd1);
    check_eq("c1_valid",   32'(code_valid), 32'd1);
    check_eq("c1_addr0",   32'(code.loops[0].uloop_addr), 32'd3);
    check_eq("c1_nbops0",  32'(code.loops[0].nb_ops), 32'd2);
    check_eq("c1_range0",  32'(code.range[0]), 32'd5);
    check_eq("c1_code0",   32'(code.code[0]), 32'h123);
    check_eq("c1_code1",   32'(code.code[1]), 32'h421);
    tick();
    check_eq("c1_pulse_end", 32'(commit_done), 32'd0);

    // Byte-enabled write and unused-bit masking
    wr(5'd1, 32'hFFFF_FFFF, 4'b0001);
    rd(5'd1);
    check_eq("be_rd",      rdata, 32'h0000_001F);
    tick();
    check_eq("be_rd_hold", rdata, 32'h0000_001F);
    rd(5'd6);
    check_eq("rd_w6",      rdata, 32'h0421_0123);
    wr(5'd30, 32'hDEAD_BEEF, 4'hF);
    rd(5'd30);
    check_eq("rd_unmapped", rdata, 32'd0);
    wr(5'd22, 32'h1234_5678, 4'hF);
    rd(5'd22);
    check_eq("rd_first_unmapped", rdata, 32'd0);

    // Same-cycle read and write returns the old word
    wr_en = 1'b1; rd_en = 1'b1; addr = 5'd1; wdata = 32'h0000_000A; be = 4'hF;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("rw_same_old", rdata, 32'h0000_001F);
    rd(5'd1);
    check_eq("rw_same_new", rdata, 32'h0000_000A);

    // Commit while busy, write during pending, release after a while
    busy = 1'b1;
    do_commit();
    check_eq("p_pending0", 32'(pending), 32'd1);
    wr(5'd6, 32'h0000_0007, 4'hF);
    for (int i = 0; i < 9; i++) begin
      check_eq("p_pending", 32'(pending), 32'd1);
      check_eq("p_code_hold", 32'(code.code[0]), 32'h123);
      check_eq("p_no_done", 32'(commit_done), 32'd0);
      tick();
    end
    busy = 1'b0;
    tick();
    check_eq("p_done",    32'(commit_done), 32'd1);
    check_eq("p_pend_off", 32'(pending), 32'd0);
    check_eq("p_code0",   32'(code.code[0]), 32'h007);
    check_eq("p_code1",   32'(code.code[1]), 32'h000);
    check_eq("p_valid",   32'(code_valid), 32'd1);

    // Write and commit in the same cycle: active takes the old word
    wr_en = 1'b1; addr = 5'd6; wdata = 32'h0000_0055; be = 4'hF; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    check_eq("wc_done",  32'(commit_done), 32'd1);
    check_eq("wc_old",   32'(code.code[0]), 32'h007);
    rd(5'd6);
    check_eq("wc_new_rd", rdata, 32'h0000_0055);

    // Clear while pending drops the commit
    busy = 1'b1;
    do_commit();
    check_eq("cl_pending", 32'(pending), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("cl_pend_off", 32'(pending), 32'd0);
    check_eq("cl_valid",    32'(code_valid), 32'd0);
    check_eq("cl_code",     32'(|code), 32'd0);
    busy = 1'b0;
    tick();
    check_eq("cl_no_done0", 32'(commit_done), 32'd0);
    tick();
    check_eq("cl_no_done1", 32'(commit_done), 32'd0);
    rd(5'd6);
    check_eq("cl_stage_zero", rdata, 32'd0);

    // Program validity check
    wr(5'd6, 32'h0000_0123, 4'hF);
    do_commit();
    check_eq("ck_base_done", 32'(commit_done), 32'd1);
    check_eq("ck_base_code", 32'(code.code[0]), 32'h123);
    wr(5'd0, 32'h0001_041E, 4'hF);   // addr 30, nb_ops 4, range 1
    do_commit();
`ifdef HWPE_CTRL_ULOOP_LOADER_CHECK_EN
    check_eq("ck_bad_error", 32'(error), 32'd1);
    check_eq("ck_bad_done",  32'(commit_done), 32'd0);
    check_eq("ck_bad_addr",  32'(code.loops[0].uloop_addr), 32'd0);
    check_eq("ck_bad_code",  32'(code.code[0]), 32'h123);
    check_eq("ck_bad_valid", 32'(code_valid), 32'd1);
    check_eq("ck_bad_pend",  32'(pending), 32'd0);
    wr(5'd0, 32'h0001_0005, 4'hF);   // nb_ops 0 with non-zero range
    do_commit();
    check_eq("ck_zero_error", 32'(error), 32'd1);
    check_eq("ck_zero_done",  32'(commit_done), 32'd0);
    wr(5'd0, 32'h0001_021E, 4'hF);   // addr 30, nb_ops 2: ends exactly at 32
    do_commit();
    check_eq("ck_good_error", 32'(error), 32'd0);
    check_eq("ck_good_done",  32'(commit_done), 32'd1);
    check_eq("ck_good_addr",  32'(code.loops[0].uloop_addr), 32'd30);
    check_eq("ck_good_nbops", 32'(code.loops[0].nb_ops), 32'd2);
`else
    check_eq("nock_error", 32'(error), 32'd0);
    check_eq("nock_done",  32'(commit_done), 32'd1);
    check_eq("nock_addr",  32'(code.loops[0].uloop_addr), 32'd30);
    check_eq("nock_nbops", 32'(code.loops[0].nb_ops), 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
